// File: rtl/cache_port_arbiter_pkg.sv
// rtl/cache_port_arbiter_pkg.sv - shared encodings and defaults for the L1 cache port arbiter
package cache_port_arbiter_pkg;

    localparam int DEFAULT_ADDR_W = 12;
    localparam int DEFAULT_DEPTH  = 4096;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } grant_e;

    // Word index derived from a byte address lies beyond the populated RAM.
    function automatic logic word_out_of_range(input logic [31:0] addr, input int depth);
        return {2'b00, addr[31:2]} >= $unsigned(depth);
    endfunction

endpackage

// File: rtl/cache_port_arbiter_arb_rr2.sv
// rtl/cache_port_arbiter_arb_rr2.sv - two-way alternating tie-break with saturating contention counter
module cache_port_arbiter_arb_rr2
    import cache_port_arbiter_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_f_i,
    input  logic             req_d_i,
    input  logic             en_i,
    input  logic             cnt_clr_i,
    output logic             gnt_valid_o,
    output grant_e           gnt_o,
    output logic [CNT_W-1:0] cnt_o
);

    grant_e           last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tie;

    always_comb begin
        tie         = req_f_i && req_d_i;
        gnt_valid_o = req_f_i || req_d_i;
        gnt_o       = GNT_FETCH;
        if (tie) begin
            if (last_q == GNT_FETCH) begin
                gnt_o = GNT_DATA;
            end
        end else if (req_d_i) begin
            gnt_o = GNT_DATA;
        end

        last_d = last_q;
        if (en_i && gnt_valid_o) begin
            last_d = gnt_o;
        end

        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (en_i && tie && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Reset to DATA so the first tie after reset goes to fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= GNT_DATA;
            cnt_q  <= '0;
        end else begin
            last_q <= last_d;
            cnt_q  <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cache_port_arbiter.sv
// rtl/cache_port_arbiter.sv - shares the single-port L1 cache RAM between fetch and load/store ports
module cache_port_arbiter
    import cache_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_ack,
    output logic              if_err,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic              d_err,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  contention_cnt
);

    state_e            state_q, state_d;
    grant_e            winner_q, winner_d;
    logic              err_q, err_d;
    logic              wr_q, wr_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic   arb_en, f_elig, d_elig, f_fault, d_fault, gnt_valid;
    grant_e gnt;

    // The port just acked still shows its old request during RESP, so it sits this round out.
    assign arb_en  = (state_q == ST_IDLE) || (state_q == ST_RESP);
    assign f_elig  = if_req && !((state_q == ST_RESP) && (winner_q == GNT_FETCH));
    assign d_elig  = d_req  && !((state_q == ST_RESP) && (winner_q == GNT_DATA));
    assign f_fault = (if_addr[1:0] != 2'b00) || word_out_of_range(if_addr, DEPTH);
    assign d_fault = word_out_of_range(d_addr, DEPTH);

    cache_port_arbiter_arb_rr2 #(
        .CNT_W(CNT_W)
    ) u_arb (
        .clk        (clk),
        .rst        (reset),
        .req_f_i    (f_elig),
        .req_d_i    (d_elig),
        .en_i       (arb_en),
        .cnt_clr_i  (cnt_clr),
        .gnt_valid_o(gnt_valid),
        .gnt_o      (gnt),
        .cnt_o      (contention_cnt)
    );

    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        err_d       = err_q;
        wr_d        = wr_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_be_d    = 4'b0000;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            ST_ACCESS: state_d = ST_RESP;
            default: begin
                state_d = ST_IDLE;
                if (gnt_valid) begin
                    winner_d = gnt;
                    if (gnt == GNT_FETCH) begin
                        err_d = f_fault;
                        wr_d  = 1'b0;
                    end else begin
                        err_d = d_fault;
                        wr_d  = d_we;
                    end
                    if (err_d) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d  = ST_ACCESS;
                        mem_en_d = 1'b1;
                        mem_we_d = wr_d;
                        if (gnt == GNT_FETCH) begin
                            mem_addr_d = if_addr[ADDR_W+1:2];
                        end else begin
                            mem_addr_d = d_addr[ADDR_W+1:2];
                            if (wr_d) begin
                                mem_be_d    = d_be;
                                mem_wdata_d = d_wdata;
                            end
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            winner_q    <= GNT_FETCH;
            err_q       <= 1'b0;
            wr_q        <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            err_q       <= err_d;
            wr_q        <= wr_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    assign if_ack   = (state_q == ST_RESP) && (winner_q == GNT_FETCH);
    assign d_ack    = (state_q == ST_RESP) && (winner_q == GNT_DATA);
    assign if_err   = if_ack && err_q;
    assign d_err    = d_ack && err_q;
    assign if_rdata = (if_ack && !err_q) ? mem_rdata : 32'h0;
    assign d_rdata  = (d_ack && !err_q && !wr_q) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb/tb_cache_port_arbiter.sv - scoreboard bench for cache_port_arbiter
module tb_cache_port_arbiter;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 4096;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_ack, if_err;
    logic [31:0]       if_rdata;
    logic              d_req, d_we;
    logic [3:0]        d_be;
    logic [31:0]       d_addr, d_wdata;
    logic              d_ack, d_err;
    logic [31:0]       d_rdata;
    logic              mem_en, mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              cnt_clr;
    logic [CNT_W-1:0]  contention_cnt;

    always #5 clk = ~clk;

    cache_port_arbiter #(
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_ack        (if_ack),
        .if_err        (if_err),
        .if_rdata      (if_rdata),
        .d_req         (d_req),
        .d_we          (d_we),
        .d_be          (d_be),
        .d_addr        (d_addr),
        .d_wdata       (d_wdata),
        .d_ack         (d_ack),
        .d_err         (d_err),
        .d_rdata       (d_rdata),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_be        (mem_be),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .cnt_clr       (cnt_clr),
        .contention_cnt(contention_cnt)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Block RAM: word i preloads to A000_0000|i except a few hand-picked words.
    logic [31:0] ram [DEPTH];
    logic        ram_init = 1'b0;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= 32'hA000_0000 | 32'(i);
            ram[4]       <= 32'hDEAD_BEEF;
            ram[8]       <= 32'hCAFE_F00D;
            ram[DEPTH-1] <= 32'h55AA_33CC;
            ram_init     <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t exp_f[$];
    exp_t exp_d[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (if_ack) begin
            if (exp_f.size() == 0) begin
                checks++; failures++;
                $display("FAIL fetch_unexpected_ack: got ack at cycle %0d, expected none", cyc);
            end else begin
                mon_e = exp_f.pop_front();
                cmp("fetch_err", 32'(if_err), 32'(mon_e.err));
                cmp("fetch_rdata", if_rdata, mon_e.rdata);
                cmp("fetch_ack_cycle", cyc, mon_e.cyc);
            end
        end
        if (d_ack) begin
            if (exp_d.size() == 0) begin
                checks++; failures++;
                $display("FAIL data_unexpected_ack: got ack at cycle %0d, expected none", cyc);
            end else begin
                mon_e = exp_d.pop_front();
                cmp("data_err", 32'(d_err), 32'(mon_e.err));
                cmp("data_rdata", d_rdata, mon_e.rdata);
                cmp("data_ack_cycle", cyc, mon_e.cyc);
            end
        end
    end

    int                men_cnt = 0;
    int                mwe_cnt = 0;
    int                men_cyc = -1;
    logic              cap_we;
    logic [3:0]        cap_be;
    logic [ADDR_W-1:0] cap_addr;
    logic [31:0]       cap_wdata;

    always @(negedge clk) begin
        if (mem_we) mwe_cnt++;
        if (mem_en) begin
            men_cnt++;
            men_cyc   = cyc;
            cap_we    = mem_we;
            cap_be    = mem_be;
            cap_addr  = mem_addr;
            cap_wdata = mem_wdata;
        end
    end

    task automatic do_fetch(input logic [31:0] addr, input logic err, input logic [31:0] rdata,
                            input int lat, input logic drop);
        exp_t e;
        bit   seen = 1'b0;
        if_addr = addr;
        if_req  = 1'b1;
        e.err = err; e.rdata = rdata; e.cyc = cyc + lat;
        exp_f.push_back(e);
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            seen = if_ack;
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL fetch_timeout: got no if_ack in 40 cycles, expected ack at cycle %0d", e.cyc);
        end
        if (drop) begin
            if_req = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic do_data(input logic we, input logic [3:0] be, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic err, input logic [31:0] rdata,
                           input int lat, input logic drop);
        exp_t e;
        bit   seen = 1'b0;
        d_we    = we;
        d_be    = be;
        d_addr  = addr;
        d_wdata = wdata;
        d_req   = 1'b1;
        e.err = err; e.rdata = rdata; e.cyc = cyc + lat;
        exp_d.push_back(e);
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            seen = d_ack;
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL data_timeout: got no d_ack in 40 cycles, expected ack at cycle %0d", e.cyc);
        end
        if (drop) begin
            d_req = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        if_req = 1'b0;
        d_req  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic paired_round(input int r);
        fork
            do_fetch(32'h300 + 4*r, 1'b0, 32'hA000_00C0 + r, 2, 1'b1);
            do_data(1'b0, 4'hF, 32'h400 + 4*r, 32'h0, 1'b0, 32'hA000_0100 + r, 4, 1'b1);
        join
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int c0, men0, mwe0;

    initial begin
        reset   = 1'b1;
        if_req  = 1'b0;
        if_addr = 32'h0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_be    = 4'h0;
        d_addr  = 32'h0;
        d_wdata = 32'h0;
        cnt_clr = 1'b0;
        repeat (3) @(negedge clk);
        cmp("rst_mem_en", 32'(mem_en), 32'h0);
        cmp("rst_mem_we", 32'(mem_we), 32'h0);
        cmp("rst_mem_be", 32'(mem_be), 32'h0);
        cmp("rst_mem_addr", 32'(mem_addr), 32'h0);
        cmp("rst_mem_wdata", mem_wdata, 32'h0);
        cmp("rst_cnt", 32'(contention_cnt), 32'h0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        cmp("idle_no_mem_en", 32'(men_cnt), 32'h0);
        cmp("idle_acks", {30'b0, if_ack, d_ack}, 32'h0);
        cmp("idle_rdata", if_rdata | d_rdata, 32'h0);

        c0 = cyc;
        do_fetch(32'h10, 1'b0, 32'hDEAD_BEEF, 2, 1'b1);
        cmp("fetch_mem_en_cycle", men_cyc, c0 + 1);
        cmp("fetch_mem_addr", 32'(cap_addr), 32'd4);
        cmp("fetch_mem_we", 32'(cap_we), 32'h0);

        do_data(1'b1, 4'b0011, 32'h20, 32'h1234_5678, 1'b0, 32'h0, 2, 1'b1);
        cmp("wr_mem_we", 32'(cap_we), 32'h1);
        cmp("wr_mem_be", 32'(cap_be), 32'h3);
        cmp("wr_mem_addr", 32'(cap_addr), 32'd8);
        cmp("wr_mem_wdata", cap_wdata, 32'h1234_5678);
        do_data(1'b0, 4'hF, 32'h20, 32'h0, 1'b0, 32'hCAFE_5678, 2, 1'b1);
        do_data(1'b0, 4'hF, 32'h3FFC, 32'h0, 1'b0, 32'h55AA_33CC, 2, 1'b1);

        men0 = men_cnt;
        mwe0 = mwe_cnt;
        do_data(1'b1, 4'hF, 32'h4000, 32'hFFFF_FFFF, 1'b1, 32'h0, 1, 1'b1);
        do_fetch(32'h6, 1'b1, 32'h0, 1, 1'b1);
        do_fetch(32'h4000, 1'b1, 32'h0, 1, 1'b1);
        do_data(1'b0, 4'hF, 32'hFFFF_FFF0, 32'h0, 1'b1, 32'h0, 1, 1'b1);
        cmp("fault_no_mem_en", men_cnt, men0);
        cmp("fault_no_mem_we", mwe_cnt, mwe0);

        d_we = 1'b1; d_be = 4'hF; d_addr = 32'h240; d_wdata = 32'hFFFF_FFFF; d_req = 1'b1;
        @(negedge clk);
        cmp("abort_in_access", 32'(mem_en), 32'h1);
        #2 reset = 1'b1;
        #1;
        cmp("abort_mem_en", 32'(mem_en), 32'h0);
        cmp("abort_mem_we", 32'(mem_we), 32'h0);
        cmp("abort_d_ack", 32'(d_ack), 32'h0);
        cmp("abort_cnt", 32'(contention_cnt), 32'h0);
        d_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        men0 = men_cnt;
        repeat (4) @(negedge clk);
        cmp("abort_stays_idle", men_cnt, men0);
        do_data(1'b0, 4'hF, 32'h240, 32'h0, 1'b0, 32'hA000_0090, 2, 1'b1);

        do_reset();
        fork
            for (int i = 0; i < 4; i++)
                do_fetch(32'h100 + 4*i, 1'b0, 32'hA000_0040 + i, (i == 0) ? 2 : 4, i == 3);
            for (int j = 0; j < 4; j++)
                do_data(1'b0, 4'hF, 32'h200 + 4*j, 32'h0, 1'b0, 32'hA000_0080 + j, 4, j == 3);
        join
        cmp("contend_cnt", 32'(contention_cnt), 32'd1);

        paired_round(0);
        cmp("tie_cnt_2", 32'(contention_cnt), 32'd2);
        paired_round(1);
        paired_round(2);
        cmp("tie_cnt_saturated", 32'(contention_cnt), 32'd3);

        cnt_clr = 1'b1;
        fork
            begin
                @(negedge clk);
                cnt_clr = 1'b0;
            end
            paired_round(3);
        join
        cmp("clr_beats_incr", 32'(contention_cnt), 32'd0);

        repeat (3) @(negedge clk);
        cmp("fetch_queue_drained", exp_f.size(), 32'd0);
        cmp("data_queue_drained", exp_d.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
Shares the single-port 32-bit L1 cache block RAM between two requesters: the CPU instruction-fetch port and the CPU load/store data port.
- Sequences every access as IDLE -> ACCESS -> RESP and drives the RAM control signals from registers.
- Checks address range and alignment before touching memory.
- Resolves ties by alternating grants.
- Keeps a saturating contention counter for debug LEDs/JTAG.
- Sits between the riscv64 core and the Cache array in the top-level board module.

Parameters:
ADDR_W, 12, word-index width of the cache RAM
DEPTH, 4096, number of 32-bit words present; valid word index is 0..DEPTH-1
CNT_W, 16, width of contention counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
if_req  in  1  fetch request, held until if_ack
if_addr  in  32  fetch byte address
if_ack  out  1  one-cycle fetch completion pulse
if_err  out  1  fetch fault (out of range or misaligned), valid with if_ack
if_rdata  out  32  fetch data, valid only while if_ack=1
d_req  in  1  data request, held with d_we/d_be/d_addr/d_wdata stable until d_ack
d_we  in  1  1=write, 0=read
d_be  in  4  byte enables for writes; ignored on reads
d_addr  in  32  data byte address
d_wdata  in  32  write data
d_ack  out  1  one-cycle data completion pulse
d_err  out  1  data fault (out of range), valid with d_ack
d_rdata  out  32  read data, valid only while d_ack=1
mem_en  out  1  RAM enable (registered)
mem_we  out  1  RAM write enable (registered)
mem_be  out  4  RAM byte enables (registered)
mem_addr  out  ADDR_W  RAM word index (registered)
mem_wdata  out  32  RAM write data (registered)
mem_rdata  in  32  RAM synchronous read data, valid the cycle after mem_en
cnt_clr  in  1  synchronous clear of contention counter
contention_cnt  out  CNT_W  saturating count of contended arbitrations

Behaviour:
Reset (async, active-high):
- State=IDLE; last_grant=DATA.
- All acks, errs, mem_en, mem_we and mem_be = 0; mem_addr/mem_wdata=0; contention_cnt=0.
- A reset mid-transaction abandons it: no ack is issued and any RAM write not yet clocked is dropped.

States:
- IDLE: arbitrate eligible requests.
  - Winner valid -> ACCESS; mem_* registered with winner's fields, mem_en=1.
  - Winner faulted -> RESP directly; mem_en stays 0.
- ACCESS: mem_en=1 for exactly one cycle -> RESP.
- RESP:
  - Winner's ack=1, err as computed.
  - rdata = mem_rdata for a valid read; rdata = 0 on err and on writes.
  - Re-arbitrate in the same cycle; the acked requester is NOT eligible this cycle, since its req still reflects the completed transaction.
  - Eligible winner -> ACCESS or RESP, as from IDLE; otherwise -> IDLE.

Arbitration:
- If only one request is eligible, it wins.
- On a tie, the requester opposite last_grant wins.
- last_grant updates on every grant.
- contention_cnt += 1 on each tie, saturating at 2^CNT_W-1.
- cnt_clr has priority over increment.

Fault and address rules:
- Fault checks: fetch faults if addr[1:0]!=0 or addr[31:2]>=DEPTH. Data faults if addr[31:2]>=DEPTH; sub-word alignment is expressed via d_be.
- A faulted write never asserts mem_we.
- mem_addr = addr[ADDR_W+1:2].

Latency, measured from the cycle req is first sampled high in IDLE:
- Valid access: ack on cycle +2.
- Faulted access: ack on cycle +1.
- Under continuous contention, each requester completes once per 4 cycles; total throughput is one access per 2 cycles.

Outputs and handshake:
- mem_* outputs are registered.
- ack/err are decoded from the state register.
- rdata is a combinational pass-through of mem_rdata, gated by ack.
- Dropping req before ack is illegal and is not handled.

Decomposition:
- Shared package: state encoding (IDLE/ACCESS/RESP), grant encoding (FETCH=0, DATA=1), default DEPTH/ADDR_W constants. These are shared with the top-level memory map macros, with Rom_base/Ram_base staying in header.vh.
- One natural sub-module: arb_rr2, the 2-way tie-break with last_grant register and contention counter. The FSM and fault check stay in the parent.

Test Plan:
- Reset/idle: reset high 3 cycles, then low with no reqs -> all outputs 0, mem_en never asserts, contention_cnt=0.
- Single fetch, addr=0x10, mem word 0xDEADBEEF -> mem_addr=4 with mem_en on cycle +1, if_ack with if_rdata=0xDEADBEEF on cycle +2, if_err=0.
- Data write then read, addr=0x20, be=4'b0011, wdata=0x12345678 -> mem_we=1, mem_be=0011, mem_addr=8; a read of the same address returns the low half updated and d_ack at +2 each.
- Simultaneous if_req and d_req held high for 8 transactions -> grants alternate F,D,F,D... (fetch first after reset), contention_cnt increments on each tie, acks spaced 2 cycles apart.
- Faults: d_addr=0x4000 (word 4096) write, and if_addr=0x6 -> err with ack at +1, mem_en and mem_we stay 0, rdata=0.
- Reset asserted during ACCESS of a write -> no ack, state IDLE, mem_en=0 immediately (async), contention_cnt=0.
